// File: rtl/tanque_sim.sv
// tanque_sim: deterministic water-tank plant driving a thermometer level-sensor bus.
// Define TANK_FAULT_EN to let falla_i force individual sensors to 0.
module tanque_sim #(
    parameter int LEVEL_W   = 8,
    parameter int FILL_DIV  = 16,
    parameter int DRAIN_DIV = 16,
    parameter int TH0       = 32,
    parameter int TH1       = 128,
    parameter int TH2       = 224,
    parameter int NIVEL_INI = 0
) (
    input  logic               ck,
    input  logic               rst_i,
    input  logic               bomba_i,
    input  logic [1:0]         demanda_i,
    input  logic [2:0]         falla_i,
    output logic [2:0]         sensores_o,
    output logic [LEVEL_W-1:0] nivel_o,
    output logic               vacio_o,
    output logic               derrame_o
);
    localparam int FW = (FILL_DIV > 1) ? $clog2(FILL_DIV) : 1;
    localparam int DW = $clog2(DRAIN_DIV);
    localparam logic [FW-1:0] F_LAST = FW'(FILL_DIV - 1);
    localparam logic [DW-1:0] M1 = DW'(DRAIN_DIV - 1);
    localparam logic [DW-1:0] M2 = DW'(DRAIN_DIV / 2 - 1);
    localparam logic [DW-1:0] M3 = DW'(DRAIN_DIV / 4 - 1);
    localparam logic [LEVEL_W-1:0] LMAX = '1;
    localparam logic [LEVEL_W-1:0] T0 = LEVEL_W'(TH0);
    localparam logic [LEVEL_W-1:0] T1 = LEVEL_W'(TH1);
    localparam logic [LEVEL_W-1:0] T2 = LEVEL_W'(TH2);
    localparam logic [LEVEL_W-1:0] INI = LEVEL_W'(NIVEL_INI);

    logic [FW-1:0]      fcnt_q, fcnt_d;
    logic [DW-1:0]      dcnt_q, dcnt_d, dmask;
    logic [LEVEL_W-1:0] nivel_q, nivel_d;
    logic [2:0]         sens_q, sens_d, fmask;
    logic               vacio_q, vacio_d, derrame_q, derrame_d;
    logic               fill_tick, drain_tick;

`ifdef TANK_FAULT_EN
    assign fmask = falla_i;
`else
    logic unused_falla;
    assign unused_falla = ^falla_i;
    assign fmask = 3'b000;
`endif

    always_comb begin
        fill_tick  = bomba_i && (fcnt_q == F_LAST);
        fcnt_d     = (bomba_i && !fill_tick) ? fcnt_q + 1'b1 : '0;
        dcnt_d     = dcnt_q + 1'b1;
        dmask      = (demanda_i == 2'd1) ? M1 : (demanda_i == 2'd2) ? M2 : M3;
        drain_tick = (demanda_i != 2'd0) && ((dcnt_q & dmask) == dmask);
        // Coincident fill and drain cancel; each direction saturates at its rail.
        nivel_d    = (fill_tick && !drain_tick && nivel_q != LMAX) ? nivel_q + 1'b1 :
                     (drain_tick && !fill_tick && nivel_q != '0)   ? nivel_q - 1'b1 : nivel_q;
        derrame_d  = derrame_q | (fill_tick && nivel_q == LMAX);
        sens_d     = {nivel_q >= T2, nivel_q >= T1, nivel_q >= T0} & ~fmask;
        vacio_d    = (nivel_q == '0);
    end

    always_ff @(posedge ck) begin
        if (rst_i) begin
            fcnt_q    <= '0;
            dcnt_q    <= '0;
            nivel_q   <= INI;
            sens_q    <= 3'b000;
            vacio_q   <= 1'b0;
            derrame_q <= 1'b0;
        end else begin
            fcnt_q    <= fcnt_d;
            dcnt_q    <= dcnt_d;
            nivel_q   <= nivel_d;
            sens_q    <= sens_d;
            vacio_q   <= vacio_d;
            derrame_q <= derrame_d;
        end
    end

    assign nivel_o    = nivel_q;
    assign sensores_o = sens_q;
    assign vacio_o    = vacio_q;
    assign derrame_o  = derrame_q;
endmodule

// File: tb/tb_tanque_sim.sv
// tb_tanque_sim: directed checks of tanque_sim on several instances that differ only in NIVEL_INI.
module tb_tanque_sim;
    logic       ck = 1'b0;
    logic       rst = 1'b0;
    logic       bomba = 1'b0;
    logic [1:0] demanda = 2'd0;
    logic [2:0] falla = 3'b000;
    int         checks = 0;
    int         failures = 0;

    logic [2:0] s0, s10, s50, s255, s230;
    logic [7:0] n0, n10, n50, n255, n230;
    logic       v0, v10, v50, v255, v230;
    logic       d0, d10, d50, d255, d230;

    always #5 ck = ~ck;

    tanque_sim #(.LEVEL_W(8), .FILL_DIV(4), .DRAIN_DIV(8), .TH0(32), .TH1(128), .TH2(224), .NIVEL_INI(0)) u0 (
        .ck(ck), .rst_i(rst), .bomba_i(bomba), .demanda_i(demanda), .falla_i(falla),
        .sensores_o(s0), .nivel_o(n0), .vacio_o(v0), .derrame_o(d0));
    tanque_sim #(.LEVEL_W(8), .FILL_DIV(4), .DRAIN_DIV(8), .TH0(32), .TH1(128), .TH2(224), .NIVEL_INI(10)) u10 (
        .ck(ck), .rst_i(rst), .bomba_i(bomba), .demanda_i(demanda), .falla_i(falla),
        .sensores_o(s10), .nivel_o(n10), .vacio_o(v10), .derrame_o(d10));
    tanque_sim #(.LEVEL_W(8), .FILL_DIV(4), .DRAIN_DIV(8), .TH0(32), .TH1(128), .TH2(224), .NIVEL_INI(50)) u50 (
        .ck(ck), .rst_i(rst), .bomba_i(bomba), .demanda_i(demanda), .falla_i(falla),
        .sensores_o(s50), .nivel_o(n50), .vacio_o(v50), .derrame_o(d50));
    tanque_sim #(.LEVEL_W(8), .FILL_DIV(4), .DRAIN_DIV(8), .TH0(32), .TH1(128), .TH2(224), .NIVEL_INI(255)) u255 (
        .ck(ck), .rst_i(rst), .bomba_i(bomba), .demanda_i(demanda), .falla_i(falla),
        .sensores_o(s255), .nivel_o(n255), .vacio_o(v255), .derrame_o(d255));
    tanque_sim #(.LEVEL_W(8), .FILL_DIV(4), .DRAIN_DIV(8), .TH0(32), .TH1(128), .TH2(224), .NIVEL_INI(230)) u230 (
        .ck(ck), .rst_i(rst), .bomba_i(bomba), .demanda_i(demanda), .falla_i(falla),
        .sensores_o(s230), .nivel_o(n230), .vacio_o(v230), .derrame_o(d230));

    task automatic step(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic do_reset(input logic b, input logic [1:0] d);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bomba = b;
        demanda = d;
        falla = 3'b000;
    endtask

    task automatic test_reset;
        do_reset(1'b0, 2'd0);
        checks++;
        if (n0 !== 8'd0 || s0 !== 3'b000 || v0 !== 1'b0 || d0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_u0: nivel=%0d sens=%b vacio=%b derrame=%b, want 0/000/0/0", n0, s0, v0, d0);
        end
        checks++;
        if (n10 !== 8'd10 || n255 !== 8'd255 || s255 !== 3'b000 || v255 !== 1'b0) begin
            failures++;
            $display("FAIL reset_ini: n10=%0d n255=%0d s255=%b v255=%b, want 10/255/000/0", n10, n255, s255, v255);
        end
        step(1);
        checks++;
        if (s0 !== 3'b000 || v0 !== 1'b1 || s255 !== 3'b111 || v255 !== 1'b0 || s50 !== 3'b001) begin
            failures++;
            $display("FAIL reset_reflect: s0=%b v0=%b s255=%b v255=%b s50=%b, want 000/1/111/0/001", s0, v0, s255, v255, s50);
        end
    endtask

    task automatic test_fill;
        int lvl, prev;
        logic [2:0] es;
        do_reset(1'b1, 2'd0);
        for (int k = 1; k <= 1000; k++) begin
            step(1);
            lvl  = (k / 4 > 255) ? 255 : k / 4;
            prev = ((k - 1) / 4 > 255) ? 255 : (k - 1) / 4;
            es   = {prev >= 224, prev >= 128, prev >= 32};
            checks++;
            if (n0 !== 8'(lvl) || s0 !== es || d0 !== 1'b0) begin
                failures++;
                $display("FAIL fill_edge%0d: nivel=%0d sens=%b derrame=%b, want %0d/%b/0", k, n0, s0, d0, lvl, es);
            end
        end
    endtask

    task automatic test_drain;
        int lvl, prev;
        do_reset(1'b0, 2'd3);
        for (int k = 1; k <= 40; k++) begin
            step(1);
            lvl  = (10 - k / 2 < 0) ? 0 : 10 - k / 2;
            prev = (10 - (k - 1) / 2 < 0) ? 0 : 10 - (k - 1) / 2;
            checks++;
            if (n10 !== 8'(lvl) || v10 !== (prev == 0) || n0 !== 8'd0) begin
                failures++;
                $display("FAIL drain_edge%0d: n10=%0d v10=%b n0=%0d, want %0d/%b/0", k, n10, v10, n0, lvl, prev == 0);
            end
        end
    endtask

    task automatic test_rates;
        int per;
        for (int d = 1; d <= 2; d++) begin
            per = (d == 1) ? 8 : 4;
            do_reset(1'b0, 2'(d));
            for (int k = 1; k <= 24; k++) begin
                step(1);
                checks++;
                if (n10 !== 8'(10 - k / per)) begin
                    failures++;
                    $display("FAIL rate%0d_edge%0d: nivel=%0d, want %0d", d, k, n10, 10 - k / per);
                end
            end
        end
    endtask

    task automatic test_simultaneous;
        do_reset(1'b1, 2'd2);
        for (int k = 1; k <= 200; k++) begin
            step(1);
            checks++;
            if (n50 !== 8'd50 || n0 !== 8'd0) begin
                failures++;
                $display("FAIL simul_edge%0d: n50=%0d n0=%0d, want 50/0", k, n50, n0);
            end
        end
    endtask

    task automatic test_overflow;
        do_reset(1'b1, 2'd0);
        step(3);
        checks++;
        if (d255 !== 1'b0 || n255 !== 8'd255) begin
            failures++;
            $display("FAIL ovf_edge3: derrame=%b nivel=%0d, want 0/255", d255, n255);
        end
        step(1);
        checks++;
        if (d255 !== 1'b1 || n255 !== 8'd255 || d230 !== 1'b0) begin
            failures++;
            $display("FAIL ovf_edge4: derrame=%b nivel=%0d d230=%b, want 1/255/0", d255, n255, d230);
        end
        bomba = 1'b0;
        demanda = 2'd3;
        step(100);
        checks++;
        if (d255 !== 1'b1 || n255 !== 8'd205) begin
            failures++;
            $display("FAIL ovf_sticky: derrame=%b nivel=%0d, want 1/205", d255, n255);
        end
        do_reset(1'b0, 2'd0);
        checks++;
        if (d255 !== 1'b0 || n255 !== 8'd255) begin
            failures++;
            $display("FAIL ovf_clear: derrame=%b nivel=%0d, want 0/255", d255, n255);
        end
    endtask

    task automatic test_reset_mid_fill;
        do_reset(1'b1, 2'd0);
        step(400);
        checks++;
        if (n0 !== 8'd100 || s0 !== 3'b001) begin
            failures++;
            $display("FAIL mid_pre: nivel=%0d sens=%b, want 100/001", n0, s0);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++;
        if (n0 !== 8'd0 || s0 !== 3'b000 || v0 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: nivel=%0d sens=%b vacio=%b, want 0/000/0", n0, s0, v0);
        end
        step(3);
        checks++;
        if (n0 !== 8'd0) begin
            failures++;
            $display("FAIL mid_edge3: nivel=%0d, want 0", n0);
        end
        step(1);
        checks++;
        if (n0 !== 8'd1) begin
            failures++;
            $display("FAIL mid_edge4: nivel=%0d, want 1", n0);
        end
    endtask

    task automatic test_fault;
        logic [2:0] e1, e2;
`ifdef TANK_FAULT_EN
        e1 = 3'b011;
        e2 = 3'b100;
`else
        e1 = 3'b111;
        e2 = 3'b111;
`endif
        do_reset(1'b0, 2'd0);
        falla = 3'b100;
        step(2);
        checks++;
        if (s230 !== e1 || n230 !== 8'd230 || v230 !== 1'b0) begin
            failures++;
            $display("FAIL fault_100: sens=%b nivel=%0d vacio=%b, want %b/230/0", s230, n230, v230, e1);
        end
        falla = 3'b011;
        step(1);
        checks++;
        if (s230 !== e2 || s255 !== e2) begin
            failures++;
            $display("FAIL fault_011: s230=%b s255=%b, want %b", s230, s255, e2);
        end
        falla = 3'b111;
        step(1);
        checks++;
        if (v0 !== 1'b1 || n0 !== 8'd0 || d0 !== 1'b0) begin
            failures++;
            $display("FAIL fault_vacio: vacio=%b nivel=%0d derrame=%b, want 1/0/0", v0, n0, d0);
        end
        falla = 3'b000;
        step(1);
        checks++;
        if (s230 !== 3'b111) begin
            failures++;
            $display("FAIL fault_release: sens=%b, want 111", s230);
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_drain;
        test_rates;
        test_simultaneous;
        test_overflow;
        test_reset_mid_fill;
        test_fault;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tanque_sim.md
# tanque_sim

Synchronous water-tank plant model for the level-pump controller's sensor interface. It consumes the controller's pump command and a demand selector. It integrates a tank level from them and drives the 3-bit thermometer level-sensor bus that the controller reads. It is used on the demo board and in closed-loop benches, so the pump controller can run against a deterministic plant.

## Interface
Parameters:
- LEVEL_W, 8: level register width; LEVEL_MAX = 2^LEVEL_W-1
- FILL_DIV, 16: clock cycles per +1 level step while pumping; ≥1
- DRAIN_DIV, 16: base drain period in cycles; power of 2, ≥4
- TH0, 32: threshold for sensores_o[0] (low sensor)
- TH1, 128: threshold for sensores_o[1] (mid sensor)
- TH2, 224: threshold for sensores_o[2] (high sensor); TH0<TH1<TH2≤LEVEL_MAX
- NIVEL_INI, 0: level loaded at reset

Ports:
- ck  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- bomba_i  in  1  pump command from controller; 1 = filling
- demanda_i  in  2  drain rate: 0 none, 1 every DRAIN_DIV, 2 every DRAIN_DIV/2, 3 every DRAIN_DIV/4 cycles
- falla_i  in  3  per-sensor stuck-at-0 injection (see Configuration)
- sensores_o  out  3  thermometer level sensors to controller
- nivel_o  out  LEVEL_W  current tank level
- vacio_o  out  1  registered, level == 0
- derrame_o  out  1  sticky overflow flag

## Operation
- Fill prescaler fcnt (0..FILL_DIV-1):
  - While bomba_i=1: increments each cycle.
  - fill_tick = (bomba_i && fcnt==FILL_DIV-1); fcnt wraps to 0 on fill_tick.
  - While bomba_i=0: fcnt cleared to 0 and fill_tick=0.
- Drain counter dcnt (0..DRAIN_DIV-1): free-running, wraps.
  - drain_tick when demanda_i≠0 and (dcnt & M)==M, with M = DRAIN_DIV-1, DRAIN_DIV/2-1, DRAIN_DIV/4-1 for demanda_i=1,2,3.
- Level update each cycle, nivel_o' = nivel_o + fill_tick − drain_tick, saturating:
  - both ticks in one cycle → unchanged
  - drain at 0 → stays 0
  - fill at LEVEL_MAX → stays LEVEL_MAX
- derrame_o sets when fill_tick && nivel_o==LEVEL_MAX. It stays 1 until rst_i, regardless of later level.
- Sensors, registered from current nivel_o:
  - sensores_o[k]' = (nivel_o ≥ THk) & ~mask[k]
  - mask = falla_i when fault injection is compiled in, else 0
  - vacio_o' = (nivel_o==0)
- demanda_i and bomba_i changes take effect on the next edge; no handshake.

## Timing
- Reset, rst_i sampled high on an edge: nivel_o=NIVEL_INI, fcnt=0, dcnt=0, sensores_o=000, vacio_o=0, derrame_o=0.
- A reset during operation discards all state on that edge.
- Sensor latency: sensores_o and vacio_o reflect nivel_o one cycle later. After reset they show 000/0 for one cycle, then reflect NIVEL_INI.
- First fill step: bomba_i held high from the first post-reset cycle → nivel_o increments on the FILL_DIV-th edge, then every FILL_DIV edges.
- First drain step: dcnt=0 after reset → first drain_tick at dcnt==M, i.e. M+1 edges after reset release.
- derrame_o is registered: it rises on the edge of the offending fill_tick.

## Configuration
- TANK_FAULT_EN defined: falla_i[k]=1 forces sensores_o[k]=0 on the next edge. nivel_o, vacio_o and derrame_o are unaffected.
- TANK_FAULT_EN undefined: falla_i remains a port but is ignored; sensores_o is pure threshold compare.

## Test plan
Parameters LEVEL_W=8, FILL_DIV=4, DRAIN_DIV=8, TH 32/128/224, NIVEL_INI=0 unless stated.

1. Fill from reset:
   - Stimulus: rst 1 cycle, bomba_i=1, demanda_i=0.
   - Response: nivel_o=1 at edge 4, 32 at edge 128; sensores_o=001 at edge 129; 011 when level reaches 128; 111 at 224.
2. Drain to empty:
   - Stimulus: NIVEL_INI=10, bomba_i=0, demanda_i=3.
   - Response: −1 every 2 cycles; nivel_o=0 at edge 20 and holds; vacio_o=1 at edge 21.
3. Simultaneous ticks:
   - Stimulus: NIVEL_INI=50, bomba_i=1, demanda_i=2 (both ticks every 4 cycles, aligned from reset).
   - Response: nivel_o stays 50 for 200 cycles.
4. Overflow:
   - Stimulus: NIVEL_INI=255, bomba_i=1.
   - Response: nivel_o stays 255; derrame_o=1 at edge 4; still 1 after bomba_i=0 for 100 cycles; 0 after rst_i.
5. Reset mid-fill:
   - Stimulus: rst_i pulsed at nivel_o=100.
   - Response: next edge nivel_o=0, sensores_o=000, fcnt restarts (next increment 4 edges after release).
6. Fault injection with TANK_FAULT_EN:
   - Stimulus: NIVEL_INI=230, falla_i=100.
   - Response: sensores_o=011. Without the macro, the same stimulus gives 111.
